// File: rtl/conv_pkg.sv
// Shared constants and elaboration helpers for the wide-to-narrow converter family.
package conv_pkg;

   localparam logic [7:0] IDLE_SYM_DEF = 8'hBC;   // K28.5

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 1; i < v; i = i * 2) r++;
      return r;
   endfunction

   function automatic bit ratio_ok(input int in_w, input int out_w);
      if (out_w <= 0) return 1'b0;
      return (in_w % out_w == 0) && (in_w / out_w >= 2);
   endfunction

endpackage

// File: rtl/conv_hold_reg.sv
// One-word pending buffer with valid flag; load and take are never asserted together.
module conv_hold_reg #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         take,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         vld
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q   <= '0;
         vld <= 1'b0;
      end else if (load) begin
         q   <= d;
         vld <= 1'b1;
      end else if (take) begin
         vld <= 1'b0;
      end
   end

endmodule

// File: rtl/conv_wide_narrow.sv
// Wide-to-narrow serialiser with valid/ready on both sides and a one-word pending buffer.
// Build option CONV_IDLE_FILL_EN: data_out shows IDLE_SYM instead of zero while valid_out is low.
module conv_wide_narrow
   import conv_pkg::*;
#(
   parameter int               IN_W      = 32,
   parameter int               OUT_W     = 8,
   parameter int               LSB_FIRST = 0,
   parameter logic [OUT_W-1:0] IDLE_SYM  = OUT_W'(IDLE_SYM_DEF)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [IN_W-1:0]   data_in,
   input  logic              valid_in,
   output logic              ready_in,
   output logic [OUT_W-1:0]  data_out,
   output logic              valid_out,
   input  logic              ready_out
);

   localparam int RATIO = IN_W / OUT_W;
   localparam int CNT_W = clog2(RATIO);

   if (!ratio_ok(IN_W, OUT_W)) begin : g_bad_ratio
      $error("conv_wide_narrow: IN_W must be an integer multiple of OUT_W with ratio >= 2");
   end

`ifdef CONV_IDLE_FILL_EN
   localparam logic [OUT_W-1:0] IDLE_VAL = IDLE_SYM;
`else
   // zero fill; IDLE_SYM has no effect in this build
   localparam logic [OUT_W-1:0] IDLE_VAL = IDLE_SYM & {OUT_W{1'b0}};
`endif

   logic [IN_W-1:0]  sh;
   logic             sh_vld;
   logic [CNT_W-1:0] cnt;
   logic [IN_W-1:0]  pend_q;
   logic             pend_vld;

   logic             accept;
   logic             fire;
   logic             last;
   logic             pend_load;
   logic             pend_take;
   logic [IN_W-1:0]  sh_next;
   logic [OUT_W-1:0] lane;

   assign ready_in  = !pend_vld;
   assign accept    = valid_in && ready_in;
   assign fire      = sh_vld && ready_out;
   assign last      = fire && (cnt == CNT_W'(RATIO - 1));
   // a word accepted while the shifter is mid-word parks in the pending buffer
   assign pend_load = accept && sh_vld && !last;
   assign pend_take = last && pend_vld;

   assign sh_next   = (LSB_FIRST != 0) ? (sh >> OUT_W) : (sh << OUT_W);
   assign lane      = (LSB_FIRST != 0) ? sh[OUT_W-1:0] : sh[IN_W-1 -: OUT_W];
   assign valid_out = sh_vld;
   assign data_out  = sh_vld ? lane : IDLE_VAL;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sh     <= '0;
         sh_vld <= 1'b0;
         cnt    <= '0;
      end else if (last) begin
         cnt <= '0;
         if (pend_vld) begin
            sh <= pend_q;
         end else if (accept) begin
            sh <= data_in;
         end else begin
            sh_vld <= 1'b0;
         end
      end else if (fire) begin
         sh  <= sh_next;
         cnt <= cnt + CNT_W'(1);
      end else if (accept && !sh_vld) begin
         sh     <= data_in;
         sh_vld <= 1'b1;
         cnt    <= '0;
      end
   end

   conv_hold_reg #(
      .W (IN_W)
   ) u_hold (
      .clk   (clk),
      .reset (reset),
      .load  (pend_load),
      .take  (pend_take),
      .d     (data_in),
      .q     (pend_q),
      .vld   (pend_vld)
   );

endmodule

// File: tb/tb_conv_wide_narrow.sv
// Directed bench: one MSB-first and one LSB-first instance share the same stimulus.
module tb_conv_wide_narrow;

`ifdef CONV_IDLE_FILL_EN
   localparam logic [7:0] IDLE_EXP = 8'hBC;
`else
   localparam logic [7:0] IDLE_EXP = 8'h00;
`endif

   logic        clk;
   logic        reset;
   logic [31:0] data_in;
   logic        valid_in;
   logic        ready_out;
   logic        ready_in_m, ready_in_l;
   logic [7:0]  data_out_m, data_out_l;
   logic        valid_out_m, valid_out_l;

   int n_chk;
   int n_err;

   conv_wide_narrow #(.IN_W(32), .OUT_W(8), .LSB_FIRST(0), .IDLE_SYM(8'hBC)) dut_m (
      .clk       (clk),
      .reset     (reset),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .ready_in  (ready_in_m),
      .data_out  (data_out_m),
      .valid_out (valid_out_m),
      .ready_out (ready_out)
   );

   conv_wide_narrow #(.IN_W(32), .OUT_W(8), .LSB_FIRST(1), .IDLE_SYM(8'hBC)) dut_l (
      .clk       (clk),
      .reset     (reset),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .ready_in  (ready_in_l),
      .data_out  (data_out_l),
      .valid_out (valid_out_l),
      .ready_out (ready_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; leaves the bench at the negedge where valid_out has dropped.
   task automatic send_word(input string tag, input logic [31:0] w);
      logic [31:0] wv;
      wv = w;
      valid_in = 1'b1;
      data_in  = wv;
      @(negedge clk);
      valid_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk({tag, " msb lane"}, 32'(data_out_m), 32'(wv[31-8*i -: 8]));
         chk({tag, " lsb lane"}, 32'(data_out_l), 32'(wv[8*i +: 8]));
         chk({tag, " valid"}, 32'(valid_out_m), 32'd1);
         @(negedge clk);
      end
      chk({tag, " valid end"}, 32'(valid_out_m), 32'd0);
      chk({tag, " idle end"}, 32'(data_out_m), 32'(IDLE_EXP));
   endtask

   initial begin
      int rdy_low;
      logic [31:0] seq_word;
      n_chk     = 0;
      n_err     = 0;
      reset     = 1'b1;
      data_in   = '0;
      valid_in  = 1'b0;
      ready_out = 1'b1;

      @(negedge clk);
      chk("rst valid_out", 32'(valid_out_m), 32'd0);
      chk("rst ready_in", 32'(ready_in_m), 32'd1);
      chk("rst data_out", 32'(data_out_m), 32'(IDLE_EXP));
      reset = 1'b0;
      @(negedge clk);

      // single word, both lane orders
      chk("ready before word", 32'(ready_in_m), 32'd1);
      send_word("deadbeef", 32'hDEADBEEF);

      // back-to-back words
      valid_in = 1'b1;
      data_in  = 32'h01020304;
      @(negedge clk);
      data_in  = 32'h05060708;
      rdy_low  = 0;
      seq_word = 32'h01020304;
      for (int i = 0; i < 8; i++) begin
         if (i == 1) valid_in = 1'b0;
         if (i == 4) seq_word = 32'h05060708;
         chk("b2b lane", 32'(data_out_m), 32'(seq_word[31-8*(i%4) -: 8]));
         chk("b2b valid", 32'(valid_out_m), 32'd1);
         if (!ready_in_m) rdy_low++;
         @(negedge clk);
      end
      chk("b2b ready_in low cycles", 32'(rdy_low), 32'd3);
      chk("b2b valid end", 32'(valid_out_m), 32'd0);

      // backpressure on the third lane
      valid_in = 1'b1;
      data_in  = 32'hDEADBEEF;
      @(negedge clk);
      valid_in = 1'b0;
      chk("bp lane0", 32'(data_out_m), 32'hDE);
      @(negedge clk);
      chk("bp lane1", 32'(data_out_m), 32'hAD);
      @(negedge clk);
      chk("bp lane2", 32'(data_out_m), 32'hBE);
      ready_out = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp hold data", 32'(data_out_m), 32'hBE);
         chk("bp hold valid", 32'(valid_out_m), 32'd1);
      end
      ready_out = 1'b1;
      @(negedge clk);
      chk("bp resume", 32'(data_out_m), 32'hEF);
      @(negedge clk);
      chk("bp valid end", 32'(valid_out_m), 32'd0);

      // async reset mid-word with a pending word
      valid_in = 1'b1;
      data_in  = 32'hDEADBEEF;
      @(negedge clk);
      chk("rst-mid lane0", 32'(data_out_m), 32'hDE);
      data_in = 32'hCAFEF00D;
      @(negedge clk);
      valid_in = 1'b0;
      chk("rst-mid lane1", 32'(data_out_m), 32'hAD);
      chk("rst-mid pend full", 32'(ready_in_m), 32'd0);
      #2 reset = 1'b1;
      #1;
      chk("rst-mid valid_out", 32'(valid_out_m), 32'd0);
      chk("rst-mid ready_in", 32'(ready_in_m), 32'd1);
      chk("rst-mid data_out", 32'(data_out_m), 32'(IDLE_EXP));
      chk("rst-mid lsb valid", 32'(valid_out_l), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post-rst no lane", 32'(valid_out_m), 32'd0);
      end
      send_word("after reset", 32'h11223344);

      // idle
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle data_out", 32'(data_out_m), 32'(IDLE_EXP));
         chk("idle valid_out", 32'(valid_out_m), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/conv_wide_narrow.md
# conv_wide_narrow

Parametrised single-clock wide-to-narrow serialiser for the 32b→8b datapath family. It accepts IN_W-bit words over a valid/ready handshake and emits them as IN_W/OUT_W consecutive OUT_W-bit lanes, with backpressure from downstream. A one-word pending buffer sustains full output rate with no bubbles between words. It replaces the fixed 32b→8b, two-clock converter wherever the narrow side runs on a single clock with flow control.

## Interface
Parameters:
- IN_W, 32, input word width; must be an integer multiple of OUT_W
- OUT_W, 8, output lane width
- LSB_FIRST, 0, 0 = most-significant lane first; 1 = least-significant lane first
- IDLE_SYM, 8'hBC, idle symbol; OUT_W bits wide; used only with CONV_IDLE_FILL_EN

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- data_in  in  IN_W  input word
- valid_in  in  1  data_in is valid
- ready_in  out  1  block can accept a word; combinational, equal to !pend_vld
- data_out  out  OUT_W  current lane; driven from registers
- valid_out  out  1  data_out is valid
- ready_out  in  1  downstream accepts the current lane

## Operation
- RATIO = IN_W/OUT_W, with RATIO ≥ 2; an elaboration-time check fails on a non-integer ratio or RATIO < 2.
- State:
  - shifter sh[IN_W-1:0] with valid flag sh_vld
  - lane counter cnt, clog2(RATIO) bits
  - pending register pend[IN_W-1:0] with flag pend_vld
- accept = valid_in && ready_in. fire = valid_out && ready_out. last = fire && cnt == RATIO-1.
- valid_out = sh_vld.
- data_out is the top OUT_W bits of sh when LSB_FIRST=0, and the bottom OUT_W bits when LSB_FIRST=1.
- On fire and not last: shift sh by OUT_W toward the output end; cnt += 1.
- On last: cnt ← 0, then load the shifter by priority:
  - from pend, clearing pend_vld, if pend_vld
  - else from data_in, if accept
  - else clear sh_vld
- On accept when not directly loaded into the shifter:
  - if sh_vld = 0: load sh from data_in, set sh_vld, cnt ← 0
  - otherwise: write data_in to pend and set pend_vld
- Simultaneous last, accept and pend_vld cannot occur, because ready_in = 0 whenever pend_vld = 1.
- Reset values: sh = 0, sh_vld = 0, cnt = 0, pend = 0, pend_vld = 0.
- Output values during and after reset: valid_out = 0, ready_in = 1, data_out = 0 (IDLE_SYM when CONV_IDLE_FILL_EN is defined).
- Reset mid-word discards the partial word and any pending word. No lane is emitted after reset is released until a new accept.
- While ready_out = 0, sh, cnt and data_out are held stable and valid_out stays high. This is AXI-style; valid is never withdrawn.

## Timing
- Latency: a word accepted at edge k, with the shifter empty, presents its first lane in the cycle after edge k.
- Throughput: one lane per cycle while ready_out = 1. Back-to-back words produce no gap in valid_out.
- After a second word lands in pend, ready_in stays low until the edge that consumes pend. With RATIO=4 that is 3 cycles.
- ready_in has no combinational dependence on valid_in or ready_out.

## Configuration
- CONV_IDLE_FILL_EN defined: data_out = IDLE_SYM whenever valid_out = 0, including during reset.
- CONV_IDLE_FILL_EN undefined: data_out = 0 whenever valid_out = 0.
- Lane content while valid_out = 1 is identical in both builds.

## Structure
- Shared package conv_pkg holds:
  - IDLE_SYM default constant (K28.5, 8'hBC)
  - clog2 helper function
  - the RATIO legality check function
- One sub-module, conv_hold_reg: the pending register with its flag.
  - Inputs: load, take, d.
  - Outputs: q, vld.
  - Same clk/reset scheme as the parent.
- Shifter, counter and output mux stay in the top module.

## Test plan
- Single word, IN_W=32, OUT_W=8, LSB_FIRST=0, data_in=0xDEADBEEF, ready_out held 1 → data_out DE, AD, BE, EF on 4 consecutive cycles with valid_out=1, then valid_out=0.
- Back-to-back words 0x01020304 then 0x05060708, valid_in held high → 8 contiguous lanes 01..08 with no valid_out gap; ready_in low for exactly 3 cycles.
- Backpressure: ready_out=0 for 5 cycles while 0xBE is presented → data_out stays 0xBE and valid_out stays 1; sequence resumes with EF.
- LSB_FIRST=1, data_in=0xDEADBEEF → lanes EF, BE, AD, DE.
- reset asserted asynchronously after the second lane (AD) → valid_out=0 and ready_in=1 immediately; no further lanes until a new word is accepted.
- Idle behaviour: no input for 10 cycles → data_out=0xBC with CONV_IDLE_FILL_EN defined, data_out=0x00 without it.
